// File: rtl/encoder_four_two_seq.sv
// Emits the binary index of each set bit of a loaded request mask, lowest first; first code 1 cycle after load.
// One code per valid&rdy&en handshake; rdy=0 holds the code, en=0 freezes state and drops valid.
module encoder_four_two_seq #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 ld,
    input  logic [N-1:0]         in,
    input  logic                 rdy,
    output logic [$clog2(N)-1:0] o,
    output logic                 valid,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    localparam int W = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_pend;
    logic           r_done;
    logic           r_zero;

    state_t         w_state_nxt;
    logic [N-1:0]   w_pend_nxt;
    logic           w_done_nxt;
    logic           w_zero_nxt;
    logic [N-1:0]   w_pend_clr;
    logic           w_accept;
    logic [W-1:0]   w_lsb_idx;

    // x & (x-1) drops the lowest set bit: the code just accepted.
    assign w_pend_clr = r_pend & (r_pend - N'(1));
    assign w_accept   = (r_state == S_SCAN) && en && rdy;

    always_comb begin
        w_lsb_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lsb_idx = W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_done  <= w_done_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_done_nxt  = 1'b0;
        w_zero_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && ld) begin
                    if (in != '0) begin
                        w_pend_nxt  = in;
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_zero_nxt  = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (w_accept) begin
                    w_pend_nxt = w_pend_clr;
                    if (w_pend_clr == '0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o     = w_lsb_idx;
        busy  = (r_state == S_SCAN);
        valid = (r_state == S_SCAN) && en;
        done  = r_done;
        zero  = r_zero;
    end

endmodule

// File: doc/encoder_four_two_seq.md
Name: encoder_four_two_seq

Overview:
- Sequential counterpart of the team's 2-to-4 decoder: captures a multi-hot request vector and emits the binary index of every set bit, lowest first, one code per accepted handshake.
- Sits upstream of decodertwo_four. Feeding o/valid into that decoder's in/en must regenerate each captured one-hot bit in turn.
- Outputs are driven only from registers. There is no combinational path from in to o or valid.

Parameters:
- N, 4, number of request lines. Must be a power of 2 and at least 2.
- W, $clog2(N) (localparam, not overridable), width of the code output (2 for N=4).

Ports:
- clk    input   1   rising-edge clock.
- rst    input   1   asynchronous, active-high reset.
- en     input   1   block enable. While 0, state is frozen and no handshake completes.
- ld     input   1   load strobe. Sampled only in IDLE with en=1.
- in     input   N   request vector, sampled when a load is taken.
- rdy    input   1   downstream ready for the current code.
- o      output  W   binary index of the lowest set bit of the pending mask.
- valid  output  1   o holds a code. Handshake completes on a clock edge with valid & rdy & en.
- busy   output  1   1 while in SCAN.
- done   output  1   one-cycle pulse in the cycle after the last code is accepted.
- zero   output  1   one-cycle pulse in the cycle after a load of an all-zero vector.

Behaviour:
- State: 2-state FSM (IDLE, SCAN) plus an N-bit register pend.
- Reset (asynchronous, takes effect immediately mid-cycle): state=IDLE, pend=0, o=0, valid=0, busy=0, done=0, zero=0.
- Combinational outputs from registers only:
  - valid = (state==SCAN) & en.
  - busy = (state==SCAN).
  - o = index of lowest set bit of pend; o=0 when pend=0.
- IDLE, edge with en=1 & ld=1:
  - in!=0: pend<=in, state<=SCAN. valid is high in the next cycle (load-to-first-code latency 1 cycle).
  - in==0: state stays IDLE; zero<=1 for exactly one cycle.
- IDLE, edge with en=0 or ld=0: no change.
- SCAN, edge with en=1 & rdy=1 (accept):
  - Clear the lowest set bit of pend.
  - If the result is 0: state<=IDLE, done<=1 for one cycle.
  - Otherwise stay in SCAN; the next code is presented the following cycle. Throughput is 1 code/cycle with rdy held high.
- SCAN, edge with rdy=0: o, pend and state all hold.
- ld while in SCAN: ignored. in is not sampled and no zero pulse is generated.
- en=0 during SCAN: valid=0, pend and state frozen, rdy ignored. Scan resumes at the same code when en returns to 1.
- done/zero defaults: both are cleared on every edge where their set condition is false. They are never high simultaneously.
- A new load is possible in the cycle done is high, since state is already IDLE.
- Codes are emitted in strictly ascending index order. Each set bit of the captured vector is emitted exactly once. The number of accepts per load equals the popcount of in.

Test Plan (N=4):
- Load in=1011, ld=1, en=1, rdy=1 held -> valid high for 3 cycles with o=0,1,3. done pulses the cycle after o=3 is accepted. busy=0 from then on.
- Load in=0110, rdy=0 for 3 cycles, then rdy=1 -> o=1, valid=1 held 3 cycles unchanged. Then o=1 accepted, o=2 accepted, done pulse, busy=0.
- Load in=0000 in IDLE -> zero=1 for exactly one cycle. valid, busy and done stay 0.
- Load in=1000, rdy=0, then pulse ld with in=0001 during SCAN -> o stays 3 and no zero pulse. On rdy=1: single accept, done, IDLE.
- Load in=1111, accept o=0, then en=0 for 2 cycles with rdy=1 -> valid=0, no pops. On en=1: o=1,2,3 in order, then done.
- Load in=1110, assert rst between clock edges -> valid, busy, o drop to 0 immediately. After rst release, a load of in=0100 yields o=2 and a clean done.
